// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one combinational ALU between two
//                valid/ready requesters; one operation in flight, result
//                registered before it is returned on the owner's channel.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [OP_W-1:0]  req_op0_i,
    input  logic [OP_W-1:0]  req_op1_i,
    input  logic [WIDTH-1:0] req_a0_i,
    input  logic [WIDTH-1:0] req_a1_i,
    input  logic [WIDTH-1:0] req_b0_i,
    input  logic [WIDTH-1:0] req_b1_i,
    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic [OP_W-1:0]  alu_select_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [OP_W-1:0]   alu_select_q, alu_select_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [1:0]        req_ready;
    logic              grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_select_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_select_q <= alu_select_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_select_d = alu_select_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_result_d = rsp_result_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = 2'b00;
        grant        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On contention the requester that did not win last time goes next.
                if (req_valid_i == 2'b11) begin
                    grant = ~last_grant_q;
                end else begin
                    grant = req_valid_i[1];
                end
                if (|req_valid_i) begin
                    req_ready    = grant ? 2'b10 : 2'b01;
                    state_d      = S_EXEC;
                    owner_d      = grant;
                    last_grant_d = grant;
                    alu_select_d = grant ? req_op1_i : req_op0_i;
                    alu_a_d      = grant ? req_a1_i  : req_a0_i;
                    alu_b_d      = grant ? req_b1_i  : req_b0_i;
                end
            end
            S_EXEC: begin
                rsp_result_d = alu_result_i;
                rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready_o  = req_ready;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign alu_select_o = alu_select_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter with a local
//                ADD/SUB/AND/OR ALU model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OP_W  = 2;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [OP_W-1:0]  req_op0, req_op1;
    logic [WIDTH-1:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [OP_W-1:0]  alu_select;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op0_i    (req_op0),
        .req_op1_i    (req_op1),
        .req_a0_i     (req_a0),
        .req_a1_i     (req_a1),
        .req_b0_i     (req_b0),
        .req_b1_i     (req_b1),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .alu_select_o (alu_select),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_result_i (alu_result),
        .busy_o       (busy)
    );

    // Team ALU: 0=ADD, 1=SUB, 2=AND, 3=OR.
    always_comb begin
        case (alu_select)
            2'd0:    alu_result = alu_a + alu_b;
            2'd1:    alu_result = alu_a - alu_b;
            2'd2:    alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  {30'd0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"},  {30'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_result"}, rsp_result,         32'd0);
        chk({tag, "_alu_sel"},    {30'd0, alu_select}, 32'd0);
        chk({tag, "_alu_a"},      alu_a,              32'd0);
        chk({tag, "_alu_b"},      alu_b,              32'd0);
        chk({tag, "_busy"},       {31'd0, busy},      32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        cyc();
        cyc();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]  exp_own [3];
        logic [31:0] exp_res [3];
        exp_own = '{2'b01, 2'b10, 2'b01};
        exp_res = '{32'd2, 32'd4, 32'd2};

        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_op0 = '0; req_op1 = '0;
        req_a0  = '0; req_a1  = '0;
        req_b0  = '0; req_b1  = '0;
        do_reset();

        // 1: single ADD from requester 0
        req_valid = 2'b01; req_op0 = 2'd0; req_a0 = 32'd10; req_b0 = 32'd25;
        rsp_ready = 2'b01;
        #1;
        chk("t1_ready", {30'd0, req_ready}, 32'h1);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);
        cyc();
        req_valid = 2'b00;
        #1;
        chk("t1_busy_exec", {31'd0, busy}, 32'd1);
        chk("t1_rsp_valid_exec", {30'd0, rsp_valid}, 32'd0);
        chk("t1_alu_a", alu_a, 32'd10);
        chk("t1_alu_b", alu_b, 32'd25);
        chk("t1_ready_exec", {30'd0, req_ready}, 32'd0);
        cyc();
        chk("t1_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        chk("t1_result", rsp_result, 32'd35);
        cyc();
        chk("t1_busy_done", {31'd0, busy}, 32'd0);
        chk("t1_rsp_valid_done", {30'd0, rsp_valid}, 32'd0);

        // 2: contention, strict alternation starting with requester 0
        do_reset();
        req_op0 = 2'd1; req_a0 = 32'd11; req_b0 = 32'd9;
        req_op1 = 2'd0; req_a1 = 32'd3;  req_b1 = 32'd1;
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_ready_%0d", k), {30'd0, req_ready}, {30'd0, exp_own[k]});
            cyc();
            chk($sformatf("t2_busy_%0d", k), {31'd0, busy}, 32'd1);
            cyc();
            chk($sformatf("t2_valid_%0d", k), {30'd0, rsp_valid}, {30'd0, exp_own[k]});
            chk($sformatf("t2_result_%0d", k), rsp_result, exp_res[k]);
            cyc();
        end

        // 3: backpressure on requester 0's response
        req_valid = 2'b01; rsp_ready = 2'b00;
        #1;
        chk("t3_ready", {30'd0, req_ready}, 32'h1);
        cyc();
        req_valid = 2'b11;
        cyc();
        chk("t3_valid", {30'd0, rsp_valid}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("t3_hold_valid_%0d", k), {30'd0, rsp_valid}, 32'h1);
            chk($sformatf("t3_hold_result_%0d", k), rsp_result, 32'd2);
            chk($sformatf("t3_hold_ready_%0d", k), {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = 2'b01;
        cyc();
        chk("t3_busy_done", {31'd0, busy}, 32'd0);
        chk("t3_valid_done", {30'd0, rsp_valid}, 32'd0);
        chk("t3_next_grant", {30'd0, req_ready}, 32'h2);

        // 4: wrap-around on requester 1
        req_valid = 2'b10; rsp_ready = 2'b10;
        req_op1 = 2'd0; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1;
        #1;
        chk("t4_ready_add", {30'd0, req_ready}, 32'h2);
        cyc();
        cyc();
        chk("t4_valid_add", {30'd0, rsp_valid}, 32'h2);
        chk("t4_result_add", rsp_result, 32'd0);
        cyc();
        req_op1 = 2'd1; req_a1 = 32'd0; req_b1 = 32'd1;
        #1;
        chk("t4_ready_sub", {30'd0, req_ready}, 32'h2);
        cyc();
        cyc();
        chk("t4_valid_sub", {30'd0, rsp_valid}, 32'h2);
        chk("t4_result_sub", rsp_result, 32'hFFFF_FFFF);
        cyc();
        req_valid = 2'b00;

        // 5a: reset asserted in EXEC
        req_op0 = 2'd0; req_a0 = 32'd10; req_b0 = 32'd25;
        req_valid = 2'b01; rsp_ready = 2'b11;
        cyc();
        chk("t5a_busy_exec", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; req_valid = 2'b00;
        #1;
        chk_reset_outputs("t5a");
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("t5a_no_rsp_%0d", k), {30'd0, rsp_valid}, 32'd0);
        end
        req_valid = 2'b11; rsp_ready = 2'b00;
        #1;
        chk("t5a_first_grant", {30'd0, req_ready}, 32'h1);

        // 5b: reset asserted in RESP
        cyc();
        cyc();
        chk("t5b_valid_resp", {30'd0, rsp_valid}, 32'h1);
        rst_n = 1'b0; req_valid = 2'b00;
        #1;
        chk_reset_outputs("t5b");
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("t5b_no_rsp_%0d", k), {30'd0, rsp_valid}, 32'd0);
        end
        req_valid = 2'b11;
        #1;
        chk("t5b_first_grant", {30'd0, req_ready}, 32'h1);

        // 6: ready from the non-owner must not complete the response
        req_valid = 2'b10; rsp_ready = 2'b01;
        #1;
        chk("t6_ready", {30'd0, req_ready}, 32'h2);
        cyc();
        req_valid = 2'b00;
        cyc();
        chk("t6_valid", {30'd0, rsp_valid}, 32'h2);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("t6_hold_valid_%0d", k), {30'd0, rsp_valid}, 32'h2);
            chk($sformatf("t6_hold_busy_%0d", k), {31'd0, busy}, 32'd1);
        end
        rsp_ready = 2'b10;
        cyc();
        chk("t6_busy_done", {31'd0, busy}, 32'd0);
        chk("t6_valid_done", {30'd0, rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
